// File: rtl/mem_dump.sv
// Debug readback engine: walks a word range through a one-cycle-latency read
// port and streams (address, data) beats over valid/ready, stalling the core.
module mem_dump #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              cpu_stall,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cur;
    logic [ADDR_W:0]     remaining;
    logic [DATA_W-1:0]   data_q;
    logic                is_last;

    assign is_last = (remaining == ONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur       <= '0;
            remaining <= '0;
            data_q    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start && count != '0) begin
                        cur       <= start_addr;
                        remaining <= count;
                    end
                end
                WAIT: data_q <= rd_data;
                SEND: begin
                    if (out_ready && !is_last) begin
                        cur       <= cur + 1'b1;
                        remaining <= remaining - ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = (count == '0) ? DONE : REQ;
            end
            REQ:  state_nxt = WAIT;
            WAIT: state_nxt = SEND;
            SEND: begin
                if (out_ready) state_nxt = is_last ? DONE : REQ;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Every output is decoded from registers only; out_ready never reaches an output.
    assign rd_en     = (state == REQ);
    assign rd_addr   = cur;
    assign out_valid = (state == SEND);
    assign out_addr  = cur;
    assign out_data  = data_q;
    assign out_last  = (state == SEND) && is_last;
    assign busy      = (state != IDLE);
    assign cpu_stall = busy;
    assign done      = (state == DONE);

endmodule

// File: tb/tb_mem_dump.sv
// Scoreboard bench for mem_dump: directed dumps against a preloaded memory
// model, with a negedge monitor popping expected beats on each handshake.
module tb_mem_dump;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  start_addr = '0;
    logic [8:0]  count = '0;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        cpu_stall;
    logic        done;

    mem_dump #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .count(count), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .out_last(out_last), .busy(busy),
        .cpu_stall(cpu_stall), .done(done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int busy_cycles = 0;
    int done_pulses = 0;
    int rd_cycles = 0;
    int valid_cycles = 0;
    int beat_cnt = 0;
    int stall_beat = -1;
    int stall_left = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: compares presented beats against the scoreboard head.
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) busy_cycles++;
            if (done) done_pulses++;
            if (rd_en) rd_cycles++;
            if (cpu_stall !== busy) begin
                n_cmp++; n_err++;
                $display("FAIL cpu_stall: got %0b expected %0b", cpu_stall, busy);
            end
            if (out_valid) begin
                valid_cycles++;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_beat: got addr %0h expected none", out_addr);
                end else begin
                    check("beat_addr", 64'(out_addr), 64'(exp_q[0].addr));
                    check("beat_data", 64'(out_data), 64'(exp_q[0].data));
                    check("beat_last", 64'(out_last), 64'(exp_q[0].last));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        beat_cnt++;
                    end
                end
            end else if (out_last) begin
                n_cmp++; n_err++;
                $display("FAIL last_outside_send: got 1 expected 0");
            end
        end
    end

    // Consumer: optionally withholds out_ready for a chosen beat.
    initial forever begin
        @(posedge clk); #1;
        if (out_valid && beat_cnt == stall_beat && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = 1'b1;
        end
    end

    task automatic clear_counts();
        busy_cycles = 0; done_pulses = 0; rd_cycles = 0;
        valid_cycles = 0; beat_cnt = 0;
    endtask

    task automatic push_expected(input logic [7:0] a, input int n);
        logic [7:0] ad;
        for (int i = 0; i < n; i++) begin
            ad = a + 8'(i);
            exp_q.push_back('{addr: ad, data: mem[ad], last: (i == n - 1)});
        end
    endtask

    task automatic issue_start(input logic [7:0] a, input logic [8:0] n);
        @(negedge clk);
        start_addr = a; count = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_dump(input logic [7:0] a, input int n, input int exp_busy);
        bit seen;
        clear_counts();
        push_expected(a, n);
        issue_start(a, 9'(n));
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 64'd1);
        @(negedge clk);
        check("busy_len", 64'(busy_cycles), 64'(exp_busy));
        check("done_pulses", 64'(done_pulses), 64'd1);
        check("beats", 64'(beat_cnt), 64'(n));
        check("reads", 64'(rd_cycles), 64'(n));
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("idle_after", 64'({busy, out_valid, done}), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, 64'({rd_en, out_valid, out_last, busy, cpu_stall, done}), 64'd0);
        check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        check({tag, "_out_addr"}, 64'(out_addr), 64'd0);
        check({tag, "_out_data"}, 64'(out_data), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Basic 3-word dump: 3N+1 busy cycles.
        run_dump(8'h10, 3, 10);
        // Address wrap across 0xFF.
        run_dump(8'hFE, 4, 13);
        // Backpressure on beat 2 for 5 cycles.
        stall_beat = 1; stall_left = 5;
        run_dump(8'h10, 3, 15);
        check("stall_used", 64'(stall_left), 64'd0);
        stall_beat = -1;
        // Zero-length dump: only a DONE cycle.
        run_dump(8'h40, 0, 1);
        check("zero_valid", 64'(valid_cycles), 64'd0);
        // Full memory sweep.
        run_dump(8'h00, 256, 769);

        // Reset in the SEND of beat 2 of a 5-word dump.
        clear_counts();
        push_expected(8'h20, 5);
        issue_start(8'h20, 9'd5);
        for (int c = 0; c < 100 && !(beat_cnt == 1 && out_valid); c++) @(negedge clk);
        check("reached_beat2", 64'(beat_cnt == 1 && out_valid), 64'd1);
        mon_en = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        mon_en = 1'b1;
        repeat (5) @(negedge clk);
        check("no_done_after_reset", 64'(done_pulses), 64'd0);
        check("no_beats_after_reset", 64'(valid_cycles), 64'd0);
        run_dump(8'h30, 2, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
